// File: rtl/cluster_serializer.sv
// Latches one event's valid-primary flags and size counts, then streams clusters in
// ascending pad order over a valid/ready link. Optional macro: OVERFLOW_COUNTER_EN.
module cluster_serializer #(
  parameter int MXROWS     = 8,
  parameter int MXKEYS     = 192,
  parameter int MXPADS     = MXROWS * MXKEYS,
  parameter int MXCNTBITS  = 3,
  parameter int MXCLUSTERS = 8
) (
  input  logic                                       clock,
  input  logic                                       reset_n,
  input  logic                                       start,
  input  logic [MXPADS-1:0]                          vpfs,
  input  logic [MXPADS*MXCNTBITS-1:0]                cnts,
  output logic                                       cluster_valid,
  input  logic                                       cluster_ready,
  output logic [$clog2(MXROWS)+$clog2(MXKEYS)-1:0]   cluster_adr,
  output logic [MXCNTBITS-1:0]                       cluster_cnt,
  output logic                                       done,
  output logic                                       overflow,
  output logic                                       busy,
  output logic                                       dropped
`ifdef OVERFLOW_COUNTER_EN
  ,
  output logic [15:0]                                overflow_cnt
`endif
);

  localparam int ROWB = $clog2(MXROWS);
  localparam int KEYB = $clog2(MXKEYS);
  localparam int PADB = $clog2(MXPADS);
  localparam int NB   = $clog2(MXCLUSTERS + 1);

  // Valid/ready: a word transfers on any clock edge where cluster_valid & cluster_ready;
  // while valid is high and ready low, adr/cnt/valid are held unchanged.
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t state;

  logic [MXPADS-1:0]           work;
  logic [MXPADS*MXCNTBITS-1:0] cnt_q;
  logic [NB-1:0]               n;

  logic                 found;
  logic [PADB-1:0]      sel_pad;
  logic [ROWB-1:0]      sel_row;
  logic [KEYB-1:0]      sel_key;
  logic [MXCNTBITS-1:0] sel_cnt;
  logic                 out_free;
  logic                 more;

  // Scan high to low so the last hit written is the lowest set pad; row/key come
  // straight from the loop indices, avoiding a divide by MXKEYS.
  always_comb begin
    found   = 1'b0;
    sel_pad = '0;
    sel_row = '0;
    sel_key = '0;
    sel_cnt = '0;
    for (int r = MXROWS - 1; r >= 0; r--) begin
      for (int k = MXKEYS - 1; k >= 0; k--) begin
        if (work[r*MXKEYS + k]) begin
          found   = 1'b1;
          sel_pad = PADB'(r*MXKEYS + k);
          sel_row = ROWB'(r);
          sel_key = KEYB'(k);
          sel_cnt = cnt_q[(r*MXKEYS + k)*MXCNTBITS +: MXCNTBITS];
        end
      end
    end
  end

  assign out_free = !cluster_valid || cluster_ready;
  assign more     = found && (n < NB'(MXCLUSTERS));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state         <= IDLE;
      work          <= '0;
      cnt_q         <= '0;
      n             <= '0;
      cluster_valid <= 1'b0;
      cluster_adr   <= '0;
      cluster_cnt   <= '0;
      overflow      <= 1'b0;
      dropped       <= 1'b0;
    end else begin
      dropped <= start && (state != IDLE);
      case (state)
        IDLE: begin
          overflow <= 1'b0;
          if (start) begin
            work  <= vpfs;
            cnt_q <= cnts;
            n     <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (out_free) begin
            if (more) begin
              cluster_adr   <= {sel_row, sel_key};
              cluster_cnt   <= sel_cnt;
              cluster_valid <= 1'b1;
              work[sel_pad] <= 1'b0;
              n             <= n + 1'b1;
            end else begin
              cluster_valid <= 1'b0;
              overflow      <= found;
              state         <= DONE;
            end
          end
        end
        DONE: begin
          overflow <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OVERFLOW_COUNTER_EN
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      overflow_cnt <= '0;
    end else if (done && overflow && overflow_cnt != 16'hFFFF) begin
      overflow_cnt <= overflow_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cluster_serializer.sv
// Directed bench for cluster_serializer: empty, single, ordering/overflow, backpressure,
// busy start and mid-event reset, scored against an expected-word queue.
module tb_cluster_serializer;

  localparam int MXPADS = 1536;
  localparam int CB     = 3;

  logic                 clock;
  logic                 reset_n;
  logic                 start;
  logic [MXPADS-1:0]    vpfs;
  logic [MXPADS*CB-1:0] cnts;
  logic                 cluster_valid;
  logic                 cluster_ready;
  logic [10:0]          cluster_adr;
  logic [CB-1:0]        cluster_cnt;
  logic                 done;
  logic                 overflow;
  logic                 busy;
  logic                 dropped;
`ifdef OVERFLOW_COUNTER_EN
  logic [15:0]          overflow_cnt;
`endif

  cluster_serializer dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .vpfs          (vpfs),
    .cnts          (cnts),
    .cluster_valid (cluster_valid),
    .cluster_ready (cluster_ready),
    .cluster_adr   (cluster_adr),
    .cluster_cnt   (cluster_cnt),
    .done          (done),
    .overflow      (overflow),
    .busy          (busy),
    .dropped       (dropped)
`ifdef OVERFLOW_COUNTER_EN
    ,
    .overflow_cnt  (overflow_cnt)
`endif
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // scoreboard
  logic [13:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_exp    = 0;
  int n_acc    = 0;
  int done_cnt = 0;
  int drop_cnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc();
    if (cluster_valid && cluster_ready) begin
      n_acc++;
      if (exp_q.size() > 0) check("word", 32'({cluster_adr, cluster_cnt}), 32'(exp_q.pop_front()));
    end
    @(posedge clock);
    #1;
    if (done)    done_cnt++;
    if (dropped) drop_cnt++;
  endtask

  task automatic clear_pads();
    vpfs = '0;
    cnts = '0;
    exp_q.delete();
    n_exp = 0;
  endtask

  task automatic add_pad(input int idx, input logic [2:0] c, input bit emitted);
    logic [2:0] row;
    logic [7:0] key;
    row = 3'(idx / 192);
    key = 8'(idx % 192);
    vpfs[idx] = 1'b1;
    cnts[idx*CB +: CB] = c;
    if (emitted) begin
      exp_q.push_back({row, key, c});
      n_exp++;
    end
  endtask

  task automatic run_event(input bit exp_ovf, input int exp_lat, input int stall_len,
                           input int busy_start_at, input int exp_drop);
    bit          got_done;
    bit          first;
    int          stall;
    int          lat;
    logic [13:0] held;
    n_acc = 0; done_cnt = 0; drop_cnt = 0;
    got_done = 0; first = 1; stall = 0; lat = -1; held = '0;
    cluster_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    check("busy_after_start", 32'(busy), 32'd1);
    for (int c = 0; c < 80; c++) begin
      if (done) begin
        got_done = 1;
        lat = c;
        break;
      end
      start = (c == busy_start_at);
      if (cluster_valid && first) begin
        first = 0;
        held  = {cluster_adr, cluster_cnt};
        stall = stall_len;
      end
      if (stall > 0) begin
        cluster_ready = 1'b0;
        check("hold_valid", 32'(cluster_valid), 32'd1);
        check("hold_word", 32'({cluster_adr, cluster_cnt}), 32'(held));
        stall--;
      end else begin
        cluster_ready = 1'b1;
      end
      cyc();
    end
    start = 1'b0;
    check("done_seen", 32'(got_done), 32'd1);
    if (exp_lat >= 0) check("done_latency", 32'(lat), 32'(exp_lat));
    check("overflow", 32'(overflow), 32'(exp_ovf));
    check("valid_at_done", 32'(cluster_valid), 32'd0);
    cluster_ready = 1'b1;
    cyc();
    check("overflow_cleared", 32'(overflow), 32'd0);
    cyc();
    check("done_pulses", 32'(done_cnt), 32'd1);
    check("busy_idle", 32'(busy), 32'd0);
    check("word_count", 32'(n_acc), 32'(n_exp));
    check("dropped_pulses", 32'(drop_cnt), 32'(exp_drop));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"},    32'(cluster_valid), 32'd0);
    check({tag, "_adr"},      32'(cluster_adr),   32'd0);
    check({tag, "_cnt"},      32'(cluster_cnt),   32'd0);
    check({tag, "_done"},     32'(done),          32'd0);
    check({tag, "_overflow"}, 32'(overflow),      32'd0);
    check({tag, "_busy"},     32'(busy),          32'd0);
    check({tag, "_dropped"},  32'(dropped),       32'd0);
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; cluster_ready = 1'b0;
    vpfs = '0; cnts = '0;
    repeat (3) cyc();
    check_all_zero("reset");
`ifdef OVERFLOW_COUNTER_EN
    check("reset_ovf_cnt", 32'(overflow_cnt), 32'd0);
`endif
    reset_n = 1'b1;
    cyc();

    // empty event: done one edge after the start edge
    clear_pads();
    run_event(1'b0, 1, 0, -1, 0);

    // single pad 389 -> row 2, key 5
    clear_pads();
    add_pad(389, 3'd3, 1'b1);
    run_event(1'b0, 2, 0, -1, 0);

    // ten flags, only the lowest eight emitted
    clear_pads();
    add_pad(0,    3'd1, 1'b1);
    add_pad(7,    3'd2, 1'b1);
    add_pad(191,  3'd7, 1'b1);
    add_pad(192,  3'd4, 1'b1);
    add_pad(500,  3'd5, 1'b1);
    add_pad(700,  3'd6, 1'b1);
    add_pad(900,  3'd0, 1'b1);
    add_pad(1100, 3'd3, 1'b1);
    add_pad(1300, 3'd2, 1'b0);
    add_pad(1535, 3'd7, 1'b0);
    run_event(1'b1, 9, 0, -1, 0);
`ifdef OVERFLOW_COUNTER_EN
    check("ovf_cnt", 32'(overflow_cnt), 32'd1);
`endif

    // backpressure on the first word
    clear_pads();
    add_pad(10,  3'd5, 1'b1);
    add_pad(200, 3'd1, 1'b1);
    add_pad(999, 3'd6, 1'b1);
    run_event(1'b0, -1, 5, -1, 0);

    // start while busy is dropped
    clear_pads();
    add_pad(3,    3'd2, 1'b1);
    add_pad(384,  3'd4, 1'b1);
    add_pad(1535, 3'd7, 1'b1);
    run_event(1'b0, 4, 0, 1, 1);

    // reset after two accepted words
    clear_pads();
    for (int i = 0; i < 6; i++) add_pad(i * 100 + 1, 3'(i + 1), 1'b1);
    n_acc = 0;
    cluster_ready = 1'b1;
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (n_acc >= 2) break;
      cyc();
    end
    check("acc_before_reset", 32'(n_acc), 32'd2);
    cluster_ready = 1'b0;
    reset_n = 1'b0;
    cyc();
    check_all_zero("midreset");
    reset_n = 1'b1;
    cyc();

    // eight fresh flags: a stale n would cut this short and raise overflow
    clear_pads();
    for (int i = 0; i < 8; i++) add_pad(i * 150 + 20, 3'(7 - i), 1'b1);
    run_event(1'b0, 9, 0, -1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
